// File: rtl/seq_frame_pkg.sv
// ============================================================================
// seq_frame_pkg : shared state encoding and default constants for seq_frame_tx
// Revision      : 1.0
// ============================================================================
`default_nettype none

package seq_frame_pkg;

    localparam int                  c_FRAME_W  = 4;
    localparam logic [c_FRAME_W-1:0] c_PAT_A   = 4'b1100;
    localparam logic [c_FRAME_W-1:0] c_PAT_B   = 4'b0011;
    localparam logic                c_IDLE_BIT = 1'b0;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

endpackage

`default_nettype wire

// File: rtl/seq_frame_tx_piso.sv
// ============================================================================
// seq_piso : parallel-load / shift-left register, MSB is the serial output
// Revision : 1.0
// ============================================================================
`default_nettype none

module seq_piso #(
    parameter int   WIDTH = 4,
    parameter logic FILL  = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] din,
    output logic             msb
);

    logic [WIDTH-1:0] r_sreg;

    // Shifting in FILL means a drained register naturally presents the idle level.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sreg <= {WIDTH{FILL}};
        end else if (load) begin
            r_sreg <= din;
        end else if (shift) begin
            r_sreg <= {r_sreg[WIDTH-2:0], FILL};
        end
    end

    assign msb = r_sreg[WIDTH-1];

endmodule

`default_nettype wire

// File: rtl/seq_frame_tx.sv
// ============================================================================
// seq_frame_tx : frame serializer with expected-decision output for the
//                sequence detector; optional checker via SEQ_FRAME_TX_CHECK_EN
// Revision     : 1.0
// ============================================================================
`default_nettype none

module seq_frame_tx
    import seq_frame_pkg::*;
#(
    parameter int                 FRAME_W  = c_FRAME_W,
    parameter logic [FRAME_W-1:0] PAT_A    = c_PAT_A,
    parameter logic [FRAME_W-1:0] PAT_B    = c_PAT_B,
    parameter logic               IDLE_BIT = c_IDLE_BIT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    input  logic [FRAME_W-1:0] in_data,
    output logic               in_ready,
    output logic               out,
    output logic               out_valid,
    output logic               frame_last,
`ifdef SEQ_FRAME_TX_CHECK_EN
    output logic               exp_dec,
    input  logic               dec_in,
    output logic               err,
    output logic [7:0]         err_cnt
`else
    output logic               exp_dec
`endif
);

    localparam int                c_CNT_W   = (FRAME_W > 1) ? $clog2(FRAME_W) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST    = c_CNT_W'(FRAME_W - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);

    state_t             r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_match;
    logic               r_out_valid;
    logic               r_frame_last;
    logic               r_exp_dec;

    logic               w_last;
    logic               w_in_ready;
    logic               w_accept;
    logic               w_match_in;
    logic               w_shift;
    logic               w_msb;
    logic [c_CNT_W-1:0] w_cnt_inc;

    assign w_last     = (r_state == SHIFT) && (r_cnt == c_LAST);
    assign w_in_ready = rst_n && ((r_state == IDLE) || w_last);
    assign w_accept   = in_valid && w_in_ready;
    assign w_match_in = (in_data == PAT_A) || (in_data == PAT_B);
    assign w_shift    = (r_state == SHIFT);
    assign w_cnt_inc  = r_cnt + c_CNT_ONE;

    seq_piso #(
        .WIDTH (FRAME_W),
        .FILL  (IDLE_BIT)
    ) u_piso (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (w_accept),
        .shift (w_shift),
        .din   (in_data),
        .msb   (w_msb)
    );

    // frame_last / exp_dec are produced one cycle ahead so they align with the bit on out.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_match      <= 1'b0;
            r_out_valid  <= 1'b0;
            r_frame_last <= 1'b0;
            r_exp_dec    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_state      <= SHIFT;
                        r_cnt        <= '0;
                        r_match      <= w_match_in;
                        r_out_valid  <= 1'b1;
                        r_frame_last <= 1'b0;
                        r_exp_dec    <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (r_cnt == c_LAST) begin
                        r_cnt        <= '0;
                        r_frame_last <= 1'b0;
                        r_exp_dec    <= 1'b0;
                        if (w_accept) begin
                            r_match     <= w_match_in;
                            r_out_valid <= 1'b1;
                        end else begin
                            r_state     <= IDLE;
                            r_out_valid <= 1'b0;
                        end
                    end else begin
                        r_cnt        <= w_cnt_inc;
                        r_frame_last <= (w_cnt_inc == c_LAST);
                        r_exp_dec    <= r_match && (w_cnt_inc == c_LAST);
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign in_ready   = w_in_ready;
    assign out        = w_msb;
    assign out_valid  = r_out_valid;
    assign frame_last = r_frame_last;
    assign exp_dec    = r_exp_dec;

`ifdef SEQ_FRAME_TX_CHECK_EN
    logic       r_err;
    logic [7:0] r_err_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_err     <= 1'b0;
            r_err_cnt <= 8'h00;
        end else if (r_out_valid && (dec_in != r_exp_dec)) begin
            r_err <= 1'b1;
            if (r_err_cnt != 8'hFF) begin
                r_err_cnt <= r_err_cnt + 8'h01;
            end
        end
    end

    assign err     = r_err;
    assign err_cnt = r_err_cnt;
`endif

endmodule

`default_nettype wire
